// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one registered SRAM port among NREQ requesters.
// Each grant runs IDLE -> ACCESS -> RESP and returns mem_q as a one-hot response.
module sram_port_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 6,
   parameter int DW   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic               busy,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_q
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state, state_d;
   logic [IDXW-1:0] rr_last, rr_last_d;
   logic [NREQ-1:0] gnt_d, rsp_valid_d;
   logic [DW-1:0]   rsp_data_d, mem_wdata_d;
   logic [AW-1:0]   mem_addr_d;
   logic            mem_we_d;

   logic            win_found;
   logic [IDXW-1:0] win_idx;
   logic [IDXW-1:0] cand;
   int              scan_idx;

   // Scan starts just after the last winner and wraps, so the last winner has lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      scan_idx  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = (int'(rr_last) + k) % NREQ;
         cand     = IDXW'(scan_idx);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state;
      rr_last_d   = rr_last;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_d     = ACCESS;
               rr_last_d   = win_idx;
               gnt_d       = NREQ'(1) << win_idx;
               mem_we_d    = req_we[win_idx];
               mem_addr_d  = req_addr[int'(win_idx)*AW +: AW];
               mem_wdata_d = req_wdata[int'(win_idx)*DW +: DW];
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            // SRAM q reflects the access sampled at the end of ACCESS.
            state_d     = IDLE;
            rsp_valid_d = NREQ'(1) << rr_last;
            rsp_data_d  = mem_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_last   <= IDXW'(NREQ-1);
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         busy      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         rr_last   <= rr_last_d;
         gnt       <= gnt_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         busy      <= (state_d != IDLE);
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, transaction-timeline reference model,
// table-driven single accesses, directed corner sequences and randomized traffic.
module tb_sram_port_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 6;
   localparam int DW   = 8;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ-1:0]    req_we = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               busy;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic [DW-1:0]      mem_q = '0;

   sram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   // Registered SRAM port with write-through q
   logic [DW-1:0] sram [64] = '{default: 8'h00};
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_q <= mem_we ? mem_wdata : sram[mem_addr];
   end

   int errors = 0;
   int checks = 0;

   // Reference model: timeline of grants and responses, plus a shadow memory
   int            n = 0;
   int            next_free = 0;
   int            last = NREQ-1;
   int            g_at = -10;
   int            rsp_at = -10;
   logic [3:0]    g_oh = '0;
   logic          g_we = 1'b0;
   logic [3:0]    rsp_oh = '0;
   logic [7:0]    rsp_dat = '0;
   logic [5:0]    e_addr = '0;
   logic [7:0]    e_wdata = '0;
   logic [7:0]    e_data = '0;
   logic [7:0]    shadow [64] = '{default: 8'h00};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic post(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
      req[i]                 = 1'b1;
      req_we[i]              = we;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   // Predict the edge from current inputs, clock it, then compare every output.
   task automatic tick();
      int         w;
      logic [1:0] wi;
      logic [5:0] a;
      logic [7:0] d;
      logic [3:0] exp_gnt;
      logic [3:0] exp_rv;
      logic       exp_we;
      logic       exp_busy;
      n++;
      if (reset) begin
         last = NREQ-1; next_free = n+1; g_at = -10; rsp_at = -10;
         e_addr = '0; e_wdata = '0; e_data = '0;
      end else if (n >= next_free && req != 0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (w < 0 && req[j]) w = j;
         end
         wi = w[1:0];
         last = w; g_at = n; g_oh = 4'(1) << wi; g_we = req_we[wi];
         a = req_addr[w*AW +: AW];
         d = req_wdata[w*DW +: DW];
         e_addr = a; e_wdata = d;
         if (g_we) begin
            shadow[a] = d;
            rsp_dat = d;
         end else begin
            rsp_dat = shadow[a];
         end
         rsp_oh = g_oh; rsp_at = n+2; next_free = n+3;
      end
      @(posedge clk);
      #1;
      exp_gnt  = (g_at == n) ? g_oh : 4'b0;
      exp_we   = (g_at == n) ? g_we : 1'b0;
      exp_busy = (n == g_at) || (n == g_at+1);
      if (rsp_at == n) begin
         exp_rv = rsp_oh;
         e_data = rsp_dat;
      end else begin
         exp_rv = 4'b0;
      end
      chk("gnt", gnt, exp_gnt);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_data", rsp_data, e_data);
      chk("busy", busy, exp_busy);
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
   endtask

   typedef struct {
      int         idx;
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic [3:0] exp_gnt;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl [7];

   task automatic single(input vec_t v);
      post(v.idx, v.we, v.addr, v.wdata);
      tick();
      chk("tbl_gnt", gnt, v.exp_gnt);
      chk("tbl_mem_we", mem_we, v.we);
      chk("tbl_mem_addr", mem_addr, v.addr);
      req[v.idx] = 1'b0;
      tick();
      chk("tbl_gnt_off", gnt, 0);
      chk("tbl_we_off", mem_we, 0);
      tick();
      chk("tbl_rsp_valid", rsp_valid, v.exp_gnt);
      chk("tbl_rsp_data", rsp_data, v.exp_data);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] order [3];
      tbl[0] = '{2, 1'b1, 6'd14, 8'hA6, 4'b0100, 8'hA6};
      tbl[1] = '{1, 1'b0, 6'd14, 8'h00, 4'b0010, 8'hA6};
      tbl[2] = '{0, 1'b1, 6'd5,  8'hD5, 4'b0001, 8'hD5};
      tbl[3] = '{3, 1'b0, 6'd5,  8'h00, 4'b1000, 8'hD5};
      tbl[4] = '{1, 1'b1, 6'd63, 8'h3C, 4'b0010, 8'h3C};
      tbl[5] = '{2, 1'b0, 6'd63, 8'h00, 4'b0100, 8'h3C};
      tbl[6] = '{0, 1'b0, 6'd14, 8'h00, 4'b0001, 8'hA6};

      do_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mem_addr", mem_addr, 0);

      for (int t = 0; t < 7; t++) single(tbl[t]);

      // All four held from reset: rotation 0,1,2,3,0 on edges 3 apart
      do_reset();
      for (int i = 0; i < NREQ; i++) post(i, 1'b0, 6'(i*3), 8'h00);
      for (int k = 1; k <= 13; k++) begin
         tick();
         if ((k-1) % 3 == 0) chk("rot_gnt", gnt, 32'(1) << (((k-1)/3) % 4));
         chk("rot_busy", busy, ((k-1) % 3) != 2);
      end
      req = '0;
      repeat (3) tick();

      // Contention after requester 2 is served: 1101 -> 3,0,2
      single('{2, 1'b0, 6'd5, 8'h00, 4'b0100, 8'hD5});
      post(0, 1'b0, 6'd14, 8'h00);
      post(2, 1'b0, 6'd63, 8'h00);
      post(3, 1'b0, 6'd5,  8'h00);
      order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b0100;
      for (int g = 0; g < 3; g++) begin
         tick();
         chk("cont_gnt", gnt, order[g]);
         req = req & ~order[g];
         tick();
         tick();
      end

      // Reset during RESP of a read drops the response
      post(1, 1'b0, 6'd14, 8'h00);
      tick();
      chk("rr_gnt", gnt, 4'b0010);
      req[1] = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_gnt0", gnt, 0);
      chk("rr_rsp_valid0", rsp_valid, 0);
      chk("rr_rsp_data0", rsp_data, 0);
      chk("rr_busy0", busy, 0);
      chk("rr_mem_we0", mem_we, 0);
      chk("rr_mem_addr0", mem_addr, 0);
      chk("rr_mem_wdata0", mem_wdata, 0);
      req = 4'b1111;
      tick();
      chk("rr_rsp_dropped", rsp_valid, 0);
      chk("rr_first_gnt", gnt, 4'b0001);
      req = '0;
      repeat (3) tick();

      // Quiet period
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_gnt", gnt, 0);
         chk("idle_rsp_valid", rsp_valid, 0);
         chk("idle_mem_we", mem_we, 0);
         chk("idle_busy", busy, 0);
      end

      // Randomized traffic obeying the hold-until-granted handshake
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else post(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               post(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
            end
         end
      end
      req = '0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
